// File: rtl/paula_pkg.sv
// Shared constants for Paula DMA FIFOs: status flag bit positions and floppy defaults.
package paula_pkg;

  localparam int unsigned FloppyWidth = 16;
  localparam int unsigned FloppyAddrW = 11;

  localparam int unsigned FlagEmpty       = 0;
  localparam int unsigned FlagFull        = 1;
  localparam int unsigned FlagAlmostFull  = 2;
  localparam int unsigned FlagAlmostEmpty = 3;
  localparam int unsigned FlagOverflow    = 4;
  localparam int unsigned FlagUnderflow   = 5;
  localparam int unsigned FlagCount       = 6;

endpackage

// File: rtl/paula_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, old data on collision.
module paula_fifo_ram #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) mem[waddr] <= wdata;
    if (en && re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/paula_dma_fifo.sv
// Paula DMA FIFO: wrap-bit pointers, look-ahead registered head word, thresholds,
// synchronous flush and sticky overflow/underflow.
module paula_dma_fifo import paula_pkg::*; #(
  parameter int unsigned WIDTH    = FloppyWidth,
  parameter int unsigned ADDR_W   = FloppyAddrW,
  parameter int unsigned AF_LEVEL = (2**ADDR_W) - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk7_en,
  input  logic              flush,
  input  logic [WIDTH-1:0]  in,
  input  logic              wr,
  input  logic              rd,
  output logic [WIDTH-1:0]  out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   cnt,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AfCnt    = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AeCnt    = AE_LEVEL[ADDR_W:0];

  logic [ADDR_W:0]    in_ptr_q, in_ptr_d, out_ptr_q, out_ptr_d, out_ptr_next;
  logic [ADDR_W:0]    cnt_w;
  logic               empty_q, empty_d, ovf_q, ovf_d, unf_q, unf_d;
  logic               primed_q;
  logic               full_w, rd_acc, wr_acc;
  logic [WIDTH-1:0]   ram_q;
  logic [FlagCount-1:0] flags;

  always_comb begin
    cnt_w        = in_ptr_q - out_ptr_q;
    full_w       = (cnt_w == DepthCnt);
    rd_acc       = rd & ~empty_q;
    wr_acc       = wr & (~full_w | rd_acc);
    out_ptr_next = out_ptr_q + {{ADDR_W{1'b0}}, rd_acc};

    in_ptr_d  = in_ptr_q + {{ADDR_W{1'b0}}, wr_acc};
    out_ptr_d = out_ptr_next;
    // Compare against the pre-edge in_ptr so a word written this edge is not yet shown.
    empty_d   = (out_ptr_next == in_ptr_q);
    ovf_d     = ovf_q | (wr & ~wr_acc);
    unf_d     = unf_q | (rd & empty_q);

    if (flush) begin
      in_ptr_d  = '0;
      out_ptr_d = '0;
      empty_d   = 1'b1;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      primed_q  <= 1'b0;
    end else if (clk7_en) begin
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      if (!flush) primed_q <= 1'b1;
    end
  end

  // Read port is frozen during flush so the head word holds its value.
  paula_fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (clk7_en),
    .we    (wr_acc & ~flush),
    .waddr (in_ptr_q[ADDR_W-1:0]),
    .wdata (in),
    .re    (~flush),
    .raddr (out_ptr_next[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  always_comb begin
    flags                  = '0;
    flags[FlagEmpty]       = empty_q;
    flags[FlagFull]        = full_w;
    flags[FlagAlmostFull]  = (cnt_w >= AfCnt);
    flags[FlagAlmostEmpty] = (cnt_w <= AeCnt);
    flags[FlagOverflow]    = ovf_q;
    flags[FlagUnderflow]   = unf_q;
  end

  // The RAM has no reset; mask its register until the first enabled read after reset.
  assign out          = primed_q ? ram_q : '0;
  assign cnt          = cnt_w;
  assign empty        = flags[FlagEmpty];
  assign full         = flags[FlagFull];
  assign almost_full  = flags[FlagAlmostFull];
  assign almost_empty = flags[FlagAlmostEmpty];
  assign overflow     = flags[FlagOverflow];
  assign underflow    = flags[FlagUnderflow];

endmodule

// File: tb/tb_paula_dma_fifo.sv
// Self-checking bench for paula_dma_fifo against a queue-based reference model.
module tb_paula_dma_fifo;

  localparam int D = 8;

  logic        clk = 1'b0, reset_n = 1'b0, clk7_en = 1'b0, flush = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [15:0] din = '0, dout;
  logic        empty, full, af, ae, ovf, unf;
  logic [3:0]  cnt;

  int checks = 0, errors = 0;
  int gate_n = 1;

  logic [15:0] q[$];
  bit          m_ovf = 0, m_unf = 0, m_empty = 1;

  paula_dma_fifo #(.WIDTH(16), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .flush(flush), .in(din), .wr(wr),
    .rd(rd), .out(dout), .empty(empty), .full(full), .almost_full(af), .almost_empty(ae),
    .cnt(cnt), .overflow(ovf), .underflow(unf)
  );

  always #5 clk = ~clk;

  // One enabled edge (preceded by gate_n-1 disabled edges); model follows the rules directly.
  task automatic step(input bit w, input bit r, input bit f, input logic [15:0] d);
    bit racc, wacc;
    wr = w; rd = r; flush = f; din = d;
    for (int i = 1; i < gate_n; i++) begin
      clk7_en = 1'b0; @(posedge clk); @(negedge clk);
    end
    clk7_en = 1'b1;
    @(posedge clk);
    if (f) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_empty = 1;
    end else begin
      racc = r && !m_empty;
      wacc = w && (q.size() < D || racc);
      if (r && m_empty) m_unf = 1;
      if (w && !wacc) m_ovf = 1;
      if (racc) void'(q.pop_front());
      m_empty = (q.size() == 0);
      if (wacc) q.push_back(d);
    end
    @(negedge clk);
    clk7_en = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_out got %h want 0", dout); end
    checks++; if (full !== 1'b0 || af !== 1'b0) begin errors++; $display("FAIL reset_full got %b%b want 00", full, af); end
    checks++; if (ae !== 1'b1) begin errors++; $display("FAIL reset_ae got %b want 1", ae); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b want 00", ovf, unf); end
    reset_n = 1'b1;
  endtask

  task automatic test_fill_drain(input string tag);
    logic [15:0] exp;
    step(0, 0, 1, 16'h0);
    for (int i = 0; i < 8; i++) begin
      exp = 16'h1111 * (i + 1);
      step(1, 0, 0, exp);
      checks++; if (cnt !== 4'(i + 1)) begin errors++; $display("FAIL %s fill_cnt got %0d want %0d", tag, cnt, i + 1); end
    end
    checks++; if (full !== 1'b1 || af !== 1'b1) begin errors++; $display("FAIL %s full_flags got %b%b want 11", tag, full, af); end
    checks++; if (empty !== 1'b0 || dout !== 16'h1111) begin errors++; $display("FAIL %s head got %b/%h want 0/1111", tag, empty, dout); end
    step(1, 0, 0, 16'h9999);
    checks++; if (ovf !== 1'b1 || cnt !== 4'd8) begin errors++; $display("FAIL %s overflow got %b/%0d want 1/8", tag, ovf, cnt); end
    for (int i = 0; i < 8; i++) begin
      exp = 16'h1111 * (i + 1);
      checks++; if (empty !== 1'b0 || dout !== exp) begin errors++; $display("FAIL %s drain got %b/%h want 0/%h", tag, empty, dout, exp); end
      step(0, 1, 0, 16'h0);
    end
    checks++; if (empty !== 1'b1 || cnt !== 4'd0 || ae !== 1'b1) begin errors++; $display("FAIL %s drained got %b/%0d/%b want 1/0/1", tag, empty, cnt, ae); end
    step(0, 1, 0, 16'h0);
    checks++; if (unf !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL %s underflow got %b/%b want 1/1", tag, unf, ovf); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] last;
    step(0, 0, 1, 16'h0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 16'($urandom));
    step(1, 1, 0, 16'hAAAA);
    checks++; if (cnt !== 4'd8 || ovf !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL full_rdwr got %0d/%b/%b want 8/0/1", cnt, ovf, full); end
    last = '0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (dout !== q[0]) begin errors++; $display("FAIL full_rdwr_drain got %h want %h", dout, q[0]); end
      last = dout;
      step(0, 1, 0, 16'h0);
    end
    checks++; if (last !== 16'hAAAA) begin errors++; $display("FAIL full_rdwr_last got %h want aaaa", last); end
    step(0, 0, 1, 16'h0);
    step(1, 1, 0, 16'h5A5A);
    checks++; if (unf !== 1'b1 || empty !== 1'b1 || cnt !== 4'd1) begin errors++; $display("FAIL empty_rdwr got %b/%b/%0d want 1/1/1", unf, empty, cnt); end
    step(0, 0, 0, 16'h0);
    checks++; if (empty !== 1'b0 || dout !== 16'h5A5A) begin errors++; $display("FAIL empty_rdwr_late got %b/%h want 0/5a5a", empty, dout); end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 16'h0);
    step(1, 0, 0, 16'd0);
    step(0, 0, 0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      checks++; if (empty !== 1'b0 || dout !== 16'(i)) begin errors++; $display("FAIL wrap_data got %b/%h want 0/%h", empty, dout, 16'(i)); end
      step(1, 1, 0, 16'(i + 1));
      checks++; if (empty !== 1'b1 || cnt > 4'd2 || full !== 1'b0) begin errors++; $display("FAIL wrap_pulse got %b/%0d/%b want 1/<=2/0", empty, cnt, full); end
      step(0, 0, 0, 16'h0);
    end
  endtask

  task automatic test_flush();
    logic [15:0] head;
    step(0, 0, 1, 16'h0);
    step(0, 1, 0, 16'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'($urandom));
    head = q[0];
    checks++; if (cnt !== 4'd5 || unf !== 1'b1) begin errors++; $display("FAIL preflush got %0d/%b want 5/1", cnt, unf); end
    step(1, 0, 1, 16'hBEEF);
    checks++; if (cnt !== 4'd0 || empty !== 1'b1 || unf !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL flush got %0d/%b/%b/%b want 0/1/0/0", cnt, empty, unf, ovf); end
    checks++; if (dout !== head) begin errors++; $display("FAIL flush_hold got %h want %h", dout, head); end
    step(0, 0, 0, 16'h0);
    checks++; if (cnt !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_discard got %0d/%b want 0/1", cnt, empty); end
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 16'h0);
    step(0, 1, 0, 16'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'($urandom));
    step(0, 0, 0, 16'h0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || cnt !== 4'd0 || dout !== 16'h0) begin errors++; $display("FAIL areset_main got %b/%0d/%h want 1/0/0", empty, cnt, dout); end
    checks++; if (full !== 1'b0 || af !== 1'b0 || ae !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL areset_flags got %b%b%b%b%b want 00100", full, af, ae, ovf, unf); end
    @(negedge clk);
    reset_n = 1'b1;
    q.delete(); m_ovf = 0; m_unf = 0; m_empty = 1;
  endtask

  task automatic test_clock_enable();
    gate_n = 4;
    test_fill_drain("gated");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'($urandom));
    wr = 1'b1; rd = 1'b1; flush = 1'b1; clk7_en = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); @(negedge clk); end
    checks++; if (cnt !== 4'd5 || empty !== 1'b0 || dout !== q[0]) begin errors++; $display("FAIL en_hold got %0d/%b/%h want 5/0/%h", cnt, empty, dout, q[0]); end
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
    gate_n = 1;
  endtask

  task automatic test_random();
    bit w, r, f;
    step(0, 0, 1, 16'h0);
    for (int n = 0; n < 400; n++) begin
      w = (n < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      r = (n < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      f = ($urandom_range(49) == 0);
      step(w, r, f, 16'($urandom));
      checks++; if (cnt !== 4'(q.size()) || empty !== m_empty) begin errors++; $display("FAIL rnd_state n=%0d got %0d/%b want %0d/%b", n, cnt, empty, q.size(), m_empty); end
      checks++; if (full !== (q.size() == D) || af !== (q.size() >= 6) || ae !== (q.size() <= 2)) begin errors++; $display("FAIL rnd_level n=%0d got %b%b%b size %0d", n, full, af, ae, q.size()); end
      checks++; if (ovf !== m_ovf || unf !== m_unf) begin errors++; $display("FAIL rnd_err n=%0d got %b%b want %b%b", n, ovf, unf, m_ovf, m_unf); end
      if (!m_empty) begin
        checks++; if (dout !== q[0]) begin errors++; $display("FAIL rnd_head n=%0d got %h want %h", n, dout, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain("full_rate");
    test_simultaneous();
    test_wrap();
    test_flush();
    test_async_reset();
    test_clock_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/paula_dma_fifo.md
# paula_dma_fifo

Parametrised synchronous FIFO for Paula DMA paths: floppy MFM buffering, with audio/disk-DMA reuse at other widths and depths. It sits between a DMA producer and a bus-side consumer, both in the `clk`/`clk7_en` domain. Over the single-purpose floppy FIFO it adds:
- generic width and depth;
- a registered head word that is always valid while not empty;
- almost-full and almost-empty thresholds;
- a synchronous flush;
- sticky overflow and underflow error flags.

## Interface
- `WIDTH`, 16, data word width in bits.
- `ADDR_W`, 11, log2 of depth; DEPTH = 2^ADDR_W words.
- `AF_LEVEL`, 2^ADDR_W-4, almost_full asserts when cnt >= AF_LEVEL.
- `AE_LEVEL`, 4, almost_empty asserts when cnt <= AE_LEVEL.

- `clk` in 1: bus clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `clk7_en` in 1: clock enable; all state changes only on rising `clk` with `clk7_en`=1.
- `flush` in 1: synchronous clear.
- `in` in WIDTH: write data.
- `wr` in 1: write request.
- `rd` in 1: read request; pops the head word.
- `out` in WIDTH → **direction out**, WIDTH: registered head word; valid when `empty`=0.
- `empty` out 1: registered.
- `full` out 1: combinational from pointers.
- `almost_full` out 1.
- `almost_empty` out 1.
- `cnt` out ADDR_W+1: stored words, 0..DEPTH.
- `overflow` out 1: sticky.
- `underflow` out 1: sticky.

## Operation
- Pointers `in_ptr` and `out_ptr` are ADDR_W+1 bits. The RAM is addressed by the low ADDR_W bits; the MSB is the wrap bit.
- Arithmetic:
  - cnt = in_ptr - out_ptr, modulo 2^(ADDR_W+1).
  - full = (cnt == DEPTH).
  - almost flags are combinational compares on cnt.
- Write acceptance: wr_acc = wr & (~full | rd_acc).
  - A write while full with no accepted read is dropped and sets `overflow`.
- Read acceptance: rd_acc = rd & ~empty.
  - A read while `empty`=1 is ignored and sets `underflow`, including when `wr` is high in the same cycle.
- Full with simultaneous rd and wr: both are accepted, cnt is unchanged, and `overflow` stays 0.
- Look-ahead read:
  - out_ptr_next = out_ptr + rd_acc.
  - Each enabled edge: `out` <= mem[out_ptr_next], then `empty` <= (out_ptr_next == in_ptr), using the pre-edge `in_ptr`.
- Read-during-write to the same address returns old data. The empty term above hides this, so a newly written word is never presented before it is readable.
- `flush` (enabled edge):
  - in_ptr = out_ptr = 0, `empty`=1;
  - `overflow` and `underflow` cleared;
  - RAM contents untouched, `out` holds its value;
  - flush has priority over rd and wr in the same cycle.
- `reset_n`=0 (async): pointers 0, `out`=0, `empty`=1, `overflow`=0, `underflow`=0. Resulting outputs: `full`=0, cnt=0, `almost_empty`=1, `almost_full`=0.

## Timing
- Write-to-visible latency: a word written at enabled edge N (FIFO empty) gives `empty`=0 and `out`=word after edge N+1. cnt=1 already after edge N.
- Read: after an enabled edge with rd_acc, `out` shows the next word, or `empty`=1 if none remain.
- Full drain: consumer may assert rd back-to-back on every enabled cycle while `empty`=0.
- Read into a just-written slot (rd_acc and wr_acc, cnt=1 before the edge): `empty` pulses 1 for one enabled cycle, then falls with the new word on `out`.
- Wrap-around: pointers wrap freely. `full` versus empty is resolved by the MSB, so cnt stays correct across any number of wraps.
- `clk7_en`=0: all registers hold. Combinational outputs remain consistent with the held state.

## Structure
- Shared `paula_pkg` holds the FIFO flag bit-index constants and the default WIDTH/ADDR_W for the floppy instance.
- Sub-module `paula_fifo_ram`:
  - simple dual-port block RAM, one write port and one registered read port, both on `clk`/`clk7_en`;
  - no reset;
  - inferable on Cyclone V M10K.
- The top level holds the pointers, flags and the empty register.

## Test plan
- Reset and fill (WIDTH=16, ADDR_W=3): after reset, `empty`=1, cnt=0, `out`=0. Write 0x1111..0x8888 on 8 consecutive enabled cycles → cnt=8, `full`=1, `almost_full`=1. A 9th write → `overflow`=1, cnt stays 8.
- Drain order: read 8 times back-to-back → `out` sequence 0x1111..0x8888, then `empty`=1. A 9th read → `underflow`=1.
- Simultaneous events:
  - when full, rd+wr of 0xAAAA → cnt=8 with no overflow, and 0xAAAA is the last word read;
  - when empty, rd+wr → write accepted, `underflow`=1, `empty` falls one enabled edge later.
- Wrap: 20 write/read pairs with values 0..19 at cnt=1 → every output matches its input, cnt never exceeds 2, `full` never asserts.
- Flush/reset mid-operation:
  - `flush` with cnt=5 and wr=1 → cnt=0, `empty`=1, flags cleared, the concurrent write is discarded;
  - async `reset_n` pulse mid-burst, between clock edges → outputs reach reset values immediately.
- Clock enable: `clk7_en` toggled at 1/4 duty during the fill/drain scenario → results identical to the full-rate run.
